// File: rtl/lut_pkg.sv
// Shared constants and state encoding for the LUT access arbiter.
package lut_pkg;

  localparam int LUT_ADDR_W = 5;
  localparam int LUT_DATA_W = 8;
  localparam int LUT_DEPTH  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } lut_arb_state_t;

endpackage

// File: rtl/lut_access_arb_rr_pick.sv
// Combinational round-robin picker: first set request bit after ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id
);

  // Scan from farthest offset down so the nearest offset after ptr wins.
  always_comb begin
    logic [ID_W-1:0] idx;
    idx       = '0;
    gnt_id    = '0;
    gnt_valid = |req;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (req[idx]) begin
        gnt_id = idx;
      end else begin
        gnt_id = gnt_id;
      end
    end
  end

endmodule

// File: rtl/lut_access_arb.sv
// Round-robin arbiter sharing one combinational 32x8 LUT among NUM_REQ
// requesters, with a registered valid/ready response channel.
module lut_access_arb
  import lut_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int VALID_ENTRIES = 13,
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*LUT_ADDR_W-1:0] addr,
  output logic [NUM_REQ-1:0]            ack,
  output logic [LUT_ADDR_W-1:0]         lut_addr,
  input  logic [LUT_DATA_W-1:0]         lut_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [LUT_DATA_W-1:0]         rsp_data,
  output logic [ID_W-1:0]               rsp_id,
  output logic                          rsp_err
);

  localparam logic [NUM_REQ-1:0] ONE_HOT = {{(NUM_REQ-1){1'b0}}, 1'b1};

  lut_arb_state_t        state_r, state_s;
  logic [ID_W-1:0]       ptr_r, cur_id_r, gnt_id_s;
  logic                  gnt_valid_s;
  logic [LUT_ADDR_W-1:0] cur_addr_r, gnt_addr_s;
  logic                  in_range_s;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req       (req),
    .ptr       (ptr_r),
    .gnt_valid (gnt_valid_s),
    .gnt_id    (gnt_id_s)
  );

  // Select the winning requester's address slice.
  always_comb begin
    gnt_addr_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id_s == ID_W'(i)) begin
        gnt_addr_s = addr[i*LUT_ADDR_W +: LUT_ADDR_W];
      end else begin
        gnt_addr_s = gnt_addr_s;
      end
    end
  end

  // Extra bit keeps VALID_ENTRIES = 32 representable, so no error is possible then.
  assign in_range_s = ({1'b0, cur_addr_r} < 6'(VALID_ENTRIES));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (gnt_valid_s) begin
          state_s = READ;
        end else begin
          state_s = IDLE;
        end
      end
      READ: state_s = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Grant capture, LUT read and response registers; lut_addr is loaded with
  // the grant so it is already valid during READ and holds otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r      <= ID_W'(NUM_REQ - 1);
      cur_id_r   <= '0;
      cur_addr_r <= '0;
      lut_addr   <= '0;
      ack        <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= '0;
      rsp_err    <= 1'b0;
    end else begin
      ack <= '0;
      case (state_r)
        IDLE: begin
          if (gnt_valid_s) begin
            cur_id_r   <= gnt_id_s;
            cur_addr_r <= gnt_addr_s;
            lut_addr   <= gnt_addr_s;
            ack        <= ONE_HOT << gnt_id_s;
          end
        end
        READ: begin
          rsp_data  <= in_range_s ? lut_data : 8'd0;
          rsp_err   <= ~in_range_s;
          rsp_id    <= cur_id_r;
          rsp_valid <= 1'b1;
          ptr_r     <= cur_id_r;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: rsp_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_access_arb.sv
// Randomized scoreboard bench for lut_access_arb with a transaction-level
// reference model, plus a directed reset-during-response scenario.
module tb_lut_access_arb;

  localparam int NR = 4;
  localparam int VE = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req;
  logic [NR*5-1:0] addr;
  logic [NR-1:0] ack;
  logic [4:0]    lut_addr;
  logic [7:0]    lut_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [7:0]    rsp_data;
  logic [1:0]    rsp_id;
  logic          rsp_err;

  always #5 clk = ~clk;

  // Test LUT: entry k holds 60 + k.
  assign lut_data = 8'd60 + {3'd0, lut_addr};

  lut_access_arb #(.NUM_REQ(NR), .VALID_ENTRIES(VE)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .addr      (addr),
    .ack       (ack),
    .lut_addr  (lut_addr),
    .lut_data  (lut_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err)
  );

  typedef struct {
    int id;
    int a;
    int data;
    int err;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   model_on = 1'b0;
  int   m_phase, m_last;
  logic [NR-1:0] exp_now_ack, exp_next_ack;
  logic          exp_now_valid, exp_next_valid;
  int   grants = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Reference model: one call per cycle, with the inputs for the coming edge
  // already applied. Predicts ack/valid for the cycle after that edge.
  task automatic model_step();
    int w;
    exp_t e;
    exp_now_ack   = exp_next_ack;
    exp_now_valid = exp_next_valid;
    exp_next_ack  = '0;
    case (m_phase)
      0: begin
        w = -1;
        for (int k = 1; k <= NR; k++) begin
          if (w < 0 && req[(m_last + k) % NR]) w = (m_last + k) % NR;
        end
        exp_next_valid = 1'b0;
        if (w >= 0) begin
          e.id   = w;
          e.a    = int'(addr[w*5 +: 5]);
          e.err  = (e.a >= VE) ? 1 : 0;
          e.data = (e.a < VE) ? 60 + e.a : 0;
          q.push_back(e);
          exp_next_ack = 4'b0001 << w;
          m_last  = w;
          m_phase = 1;
          grants++;
        end
      end
      1: begin
        exp_next_valid = 1'b1;
        m_phase = 2;
      end
      default: begin
        if (rsp_ready) begin
          exp_next_valid = 1'b0;
          m_phase = 0;
        end else begin
          exp_next_valid = 1'b1;
        end
      end
    endcase
  endtask

  // Random requesters: hold req/addr until ack, then drop for one cycle.
  task automatic drive_random(input bit en);
    for (int i = 0; i < NR; i++) begin
      if (ack[i]) begin
        req[i] = 1'b0;
      end else if (!req[i] && en && $urandom_range(3) == 0) begin
        req[i] = 1'b1;
        addr[i*5 +: 5] = 5'($urandom_range(31));
      end
    end
    rsp_ready = ($urandom_range(9) < 7);
  endtask

  // Monitor: compares DUT outputs against the model mid-cycle.
  always @(negedge clk) begin
    if (model_on) begin
      chk("ack", 32'(ack), 32'(exp_now_ack));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_now_valid));
      if (exp_now_ack != '0 && q.size() > 0) chk("lut_addr", 32'(lut_addr), q[0].a);
      if (rsp_valid) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp actual=id%0d expected=none", rsp_id);
        end else begin
          chk("rsp_id", 32'(rsp_id), q[0].id);
          chk("rsp_data", 32'(rsp_data), q[0].data);
          chk("rsp_err", 32'(rsp_err), q[0].err);
          if (rsp_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    bit got;
    reset = 1'b1; req = '0; addr = '0; rsp_ready = 1'b0;
    m_phase = 0; m_last = NR - 1;
    exp_now_ack = '0; exp_next_ack = '0; exp_now_valid = 1'b0; exp_next_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_data", 32'(rsp_data), 0);
    chk("rst_id", 32'(rsp_id), 0);
    chk("rst_err", 32'(rsp_err), 0);
    chk("rst_lut_addr", 32'(lut_addr), 0);
    reset = 1'b0;
    model_on = 1'b1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1;
      drive_random(cyc < 2850);
      model_step();
    end
    @(negedge clk);
    model_on = 1'b0;
    chk("drained", 32'(q.size()), 0);
    if (grants < 100) chk("grant_count_low", 32'(grants), 100);

    // Reset while a response is waiting for rsp_ready.
    rsp_ready = 1'b0; req = 4'b0001; addr = 20'd3;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    chk("dir_valid_seen", 32'(got), 1);
    chk("dir_data", 32'(rsp_data), 63);
    chk("dir_id", 32'(rsp_id), 0);
    chk("dir_err", 32'(rsp_err), 0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 0);
    chk("mid_rst_data", 32'(rsp_data), 0);
    chk("mid_rst_ack", 32'(ack), 0);
    chk("mid_rst_lut_addr", 32'(lut_addr), 0);
    req = 4'b0110;
    addr = {5'd0, 5'd20, 5'd5, 5'd0};
    @(negedge clk);
    reset = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (ack != '0) got = 1'b1;
    end
    chk("post_rst_ack_seen", 32'(got), 1);
    chk("post_rst_ack", 32'(ack), 32'h2);
    chk("post_rst_lut_addr", 32'(lut_addr), 5);
    req = 4'b0100;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    chk("post_rst_data", 32'(rsp_data), 65);
    chk("post_rst_id", 32'(rsp_id), 1);
    rsp_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid && rsp_id == 2'd2) got = 1'b1;
    end
    chk("oor_seen", 32'(got), 1);
    chk("oor_err", 32'(rsp_err), 1);
    chk("oor_data", 32'(rsp_data), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
